// File: rtl/key_debouncer.sv
// key_debouncer
//   Debounces NUM_KEYS active-low board pushbuttons using a shared 1 kHz tick
//   that is derived from the clock1Khz square wave. clock1Khz is treated as
//   data: it is synchronized, and its rising edge becomes a one-cycle tick.
//   A new key level must hold for STABLE_TICKS ticks before it is accepted.
//
// Ports
//   clock        system clock, all logic on its rising edge
//   reset        synchronous, active-high reset
//   clock1Khz    divided square wave, sampled as data
//   key_n        raw pushbuttons, active-low, asynchronous
//   key_level    debounced key state, 1 = pressed (registered)
//   key_press    one-cycle pulse per accepted press (registered)
//   key_release  one-cycle pulse per accepted release (registered)
//   tick         one-cycle pulse per clock1Khz rising edge
module key_debouncer #(
  parameter int NUM_KEYS     = 4,
  parameter int STABLE_TICKS = 20
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clock1Khz,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                tick
);

  localparam logic [1:0] ST_UP         = 2'd0;
  localparam logic [1:0] ST_CHECK_DOWN = 2'd1;
  localparam logic [1:0] ST_DOWN       = 2'd2;
  localparam logic [1:0] ST_CHECK_UP   = 2'd3;

  localparam logic [7:0] STABLE_CNT = 8'(STABLE_TICKS);

  // clock1Khz synchronizer (s1, s2) and edge-history flop (s3)
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  // key_n synchronizer, released (1) after reset
  logic [NUM_KEYS-1:0] k1_q, k1_d;
  logic [NUM_KEYS-1:0] k2_q, k2_d;
  logic [NUM_KEYS-1:0] raw;

  // per-key FSM state and tick counter
  logic [1:0] state_q [NUM_KEYS];
  logic [1:0] state_d [NUM_KEYS];
  logic [7:0] cnt_q   [NUM_KEYS];
  logic [7:0] cnt_d   [NUM_KEYS];

  // registered outputs
  logic [NUM_KEYS-1:0] level_q,   level_d;
  logic [NUM_KEYS-1:0] press_q,   press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;

  always_comb begin
    s1_d = clock1Khz;
    s2_d = s1_q;
    s3_d = s2_q;
    k1_d = key_n;
    k2_d = k1_q;
  end

  assign raw  = ~k2_q;
  assign tick = s2_q & ~s3_q;

  // A raw change is checked before the tick in every CHECK state, so a
  // bounce coinciding with a tick always reverts the state and clears the
  // counter. Acceptance uses >= so the counter can never pass STABLE_CNT.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      case (state_q[i])
        ST_UP: begin
          if (raw[i]) begin
            state_d[i] = ST_CHECK_DOWN;
            cnt_d[i]   = '0;
          end
        end
        ST_CHECK_DOWN: begin
          if (!raw[i]) begin
            state_d[i] = ST_UP;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] + 8'd1 >= STABLE_CNT) begin
              state_d[i] = ST_DOWN;
              cnt_d[i]   = '0;
              level_d[i] = 1'b1;
              press_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + 8'd1;
            end
          end
        end
        ST_DOWN: begin
          if (!raw[i]) begin
            state_d[i] = ST_CHECK_UP;
            cnt_d[i]   = '0;
          end
        end
        ST_CHECK_UP: begin
          if (raw[i]) begin
            state_d[i] = ST_DOWN;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] + 8'd1 >= STABLE_CNT) begin
              state_d[i]   = ST_UP;
              cnt_d[i]     = '0;
              level_d[i]   = 1'b0;
              release_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + 8'd1;
            end
          end
        end
        default: begin
          state_d[i] = ST_UP;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      k1_q      <= '1;
      k2_q      <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= ST_UP;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      k1_q      <= k1_d;
      k2_q      <= k2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with STABLE_TICKS=4 and a 100-clock
// clock1Khz period. clock1Khz rises on the clock edge where ph becomes 0.
// A key change driven at a negedge where ph==10 enters CHECK state on the
// third following edge; ticks are consumed on edges 93, 193, 293, 393, so an
// acceptance is visible at the 393rd negedge after the drive.
module tb_key_debouncer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk1k;
  logic [3:0] key_n = 4'hF;
  logic [3:0] key_level, key_press, key_release;
  logic       tick;

  int ph = 0;
  int checks = 0;
  int failures = 0;

  key_debouncer #(.NUM_KEYS(4), .STABLE_TICKS(4)) dut (
    .clock      (clk),
    .reset      (rst),
    .clock1Khz  (clk1k),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .tick       (tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ph <= (ph == 99) ? 0 : ph + 1;
  assign clk1k = (ph < 50);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Advance to the negedge where ph equals p (bounded).
  task automatic align(input int p);
    bit ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ph == p) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL align: phase %0d not reached, got %0d", p, ph);
    end
  endtask

  // Observe n negedges; report first cycle and count of press/release on key,
  // plus pulses on any other key.
  task automatic watch(input int n, input int key, output int fp, output int np,
                       output int fr, output int nr, output int others);
    fp = -1; np = 0; fr = -1; nr = 0; others = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (key_press[key]) begin
        np++;
        if (fp < 0) fp = i;
      end
      if (key_release[key]) begin
        nr++;
        if (fr < 0) fr = i;
      end
      for (int b = 0; b < 4; b++)
        if (b != key) others += int'(key_press[b]) + int'(key_release[b]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_n = 4'hF;
    repeat (4) @(negedge clk);
    checks++;
    if ({key_level, key_press, key_release, tick} !== 13'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected %b",
               {key_level, key_press, key_release, tick}, 13'b0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({key_level, key_press, key_release} !== 12'b0) begin
      failures++;
      $display("FAIL post_reset_idle: got %b expected %b",
               {key_level, key_press, key_release}, 12'b0);
    end
  endtask

  task automatic test_tick();
    int errs = 0;
    int cnt = 0;
    align(50);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tick !== (ph == 2)) errs++;
      if (tick === 1'b1) cnt++;
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL tick_position: got %0d misplaced cycles expected 0", errs);
    end
    checks++;
    if (cnt != 2) begin
      failures++;
      $display("FAIL tick_count: got %0d expected 2", cnt);
    end
  endtask

  task automatic test_clean_press();
    int fp, np, fr, nr, oth;
    align(10);
    key_n[0] = 1'b0;
    watch(450, 0, fp, np, fr, nr, oth);
    checks++;
    if (fp != 393) begin
      failures++;
      $display("FAIL clean_press_cycle: got %0d expected 393", fp);
    end
    checks++;
    if (np != 1 || nr != 0 || oth != 0) begin
      failures++;
      $display("FAIL clean_press_pulses: got press=%0d rel=%0d other=%0d expected 1 0 0",
               np, nr, oth);
    end
    checks++;
    if (key_level !== 4'b0001) begin
      failures++;
      $display("FAIL clean_press_level: got %b expected 0001", key_level);
    end
  endtask

  task automatic test_release();
    int fp, np, fr, nr, oth;
    align(10);
    key_n[0] = 1'b1;
    watch(450, 0, fp, np, fr, nr, oth);
    checks++;
    if (fr != 393) begin
      failures++;
      $display("FAIL release_cycle: got %0d expected 393", fr);
    end
    checks++;
    if (nr != 1 || np != 0 || oth != 0) begin
      failures++;
      $display("FAIL release_pulses: got rel=%0d press=%0d other=%0d expected 1 0 0",
               nr, np, oth);
    end
    checks++;
    if (key_level !== 4'b0000) begin
      failures++;
      $display("FAIL release_level: got %b expected 0000", key_level);
    end
  endtask

  task automatic test_bounce();
    int fp, np, fr, nr, oth;
    int bad = 0;
    // 17 toggles, 30 clocks apart, the last one (to low) lands on ph==10
    align(30);
    key_n[1] = 1'b0;
    for (int i = 1; i <= 480; i++) begin
      @(negedge clk);
      bad += int'(key_press[1]) + int'(key_level[1]);
      if (i % 30 == 0) key_n[1] = ~key_n[1];
    end
    checks++;
    if (bad != 0 || key_n[1] !== 1'b0) begin
      failures++;
      $display("FAIL bounce_quiet: got %0d activity, key_n1=%b expected 0, 0", bad, key_n[1]);
    end
    watch(450, 1, fp, np, fr, nr, oth);
    checks++;
    if (fp != 393 || np != 1) begin
      failures++;
      $display("FAIL bounce_accept: got cycle=%0d count=%0d expected 393 1", fp, np);
    end
    key_n = 4'hF;
    watch(500, 1, fp, np, fr, nr, oth);
    checks++;
    if (nr != 1 || key_level !== 4'b0000) begin
      failures++;
      $display("FAIL bounce_release: got rel=%0d level=%b expected 1 0000", nr, key_level);
    end
  endtask

  task automatic test_collision();
    int fp, np, fr, nr, oth;
    int tot = 0;
    align(10);
    key_n[2] = 1'b0;
    watch(390, 2, fp, np, fr, nr, oth);
    tot += np;
    // one-cycle release glitch reaching raw together with the 4th tick
    key_n[2] = 1'b1;
    watch(1, 2, fp, np, fr, nr, oth);
    tot += np;
    key_n[2] = 1'b0;
    checks++;
    if (tot != 0 || key_level !== 4'b0000) begin
      failures++;
      $display("FAIL collision_no_accept: got press=%0d level=%b expected 0 0000", tot, key_level);
    end
    watch(450, 2, fp, np, fr, nr, oth);
    checks++;
    if (fp != 402 || np != 1) begin
      failures++;
      $display("FAIL collision_restart: got cycle=%0d count=%0d expected 402 1", fp, np);
    end
    key_n = 4'hF;
    watch(500, 2, fp, np, fr, nr, oth);
    checks++;
    if (nr != 1 || key_level !== 4'b0000) begin
      failures++;
      $display("FAIL collision_release: got rel=%0d level=%b expected 1 0000", nr, key_level);
    end
  endtask

  task automatic test_multi_key();
    int first = -1;
    logic [3:0] val = 4'b0;
    align(10);
    key_n = 4'b0000;
    for (int i = 1; i <= 450; i++) begin
      @(negedge clk);
      if (first < 0 && key_press != 4'b0) begin
        first = i;
        val = key_press;
      end
    end
    checks++;
    if (first != 393 || val !== 4'b1111) begin
      failures++;
      $display("FAIL multi_press: got cycle=%0d value=%b expected 393 1111", first, val);
    end
    checks++;
    if (key_level !== 4'b1111) begin
      failures++;
      $display("FAIL multi_level: got %b expected 1111", key_level);
    end
    align(10);
    key_n = 4'hF;
    first = -1;
    for (int i = 1; i <= 450; i++) begin
      @(negedge clk);
      if (first < 0 && key_release != 4'b0) begin
        first = i;
        val = key_release;
      end
    end
    checks++;
    if (first != 393 || val !== 4'b1111 || key_level !== 4'b0000) begin
      failures++;
      $display("FAIL multi_release: got cycle=%0d value=%b level=%b expected 393 1111 0000",
               first, val, key_level);
    end
  endtask

  task automatic test_reset_mid_check();
    int fp, np, fr, nr, oth;
    align(10);
    key_n = 4'b0111;
    watch(250, 3, fp, np, fr, nr, oth);
    checks++;
    if (np != 0) begin
      failures++;
      $display("FAIL midcheck_early: got %0d presses expected 0", np);
    end
    rst = 1'b1;
    watch(1, 3, fp, np, fr, nr, oth);
    checks++;
    if ({key_level, key_press, key_release, tick} !== 13'b0) begin
      failures++;
      $display("FAIL midcheck_reset_outputs: got %b expected %b",
               {key_level, key_press, key_release, tick}, 13'b0);
    end
    watch(2, 3, fp, np, fr, nr, oth);
    rst = 1'b0;
    // sync flops restart released, so the full debounce begins after reset
    watch(400, 3, fp, np, fr, nr, oth);
    checks++;
    if (fp != 340 || np != 1 || oth != 0) begin
      failures++;
      $display("FAIL midcheck_reaccept: got cycle=%0d count=%0d other=%0d expected 340 1 0",
               fp, np, oth);
    end
    checks++;
    if (key_level !== 4'b1000) begin
      failures++;
      $display("FAIL midcheck_level: got %b expected 1000", key_level);
    end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_clean_press();
    test_release();
    test_bounce();
    test_collision();
    test_multi_key();
    test_reset_mid_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
